// File: rtl/sr_pattern_driver.sv
// Serial S/R excitation generator: replays a WIDTH-bit pattern LSB-first onto an SR flip-flop.
// Optional q feedback checker is built when SR_DRIVER_CHECK_EN is defined.
module sr_pattern_driver #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pat_in,
  input  logic             pat_valid,
  output logic             pat_ready,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic             done,
  output logic             q_model,
  input  logic             q_fb,
  output logic             mismatch,
  input  logic             mismatch_clr
);

  localparam int unsigned IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             q_model_q, q_model_d;
  logic             q_known_q, q_known_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tgt;

  // All outputs are registered, so each appears one edge after the state that produced it.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    s_d       = 1'b0;
    r_d       = 1'b0;
    q_model_d = q_model_q;
    q_known_d = q_known_q;
    tgt       = shift_q[0];

    case (state_q)
      IDLE: begin
        if (pat_valid && ready_q) begin
          shift_d = pat_in;
          idx_d   = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (!q_known_q) begin
          s_d = tgt;
          r_d = ~tgt;
        end else begin
          s_d = tgt & ~q_model_q;
          r_d = ~tgt & q_model_q;
        end
        q_model_d = tgt;
        q_known_d = 1'b1;
        shift_d   = shift_q >> 1;
        idx_d     = idx_q + IW'(1);
        if (idx_q == IW'(WIDTH - 1)) begin
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_q == DRIVE);
    done_d  = (state_q == DONE);
    // Ready stays low through the cycle in which done is visible.
    ready_d = (state_d == IDLE) && (state_q != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      q_model_q <= 1'b0;
      q_known_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      s_q       <= s_d;
      r_q       <= r_d;
      q_model_q <= q_model_d;
      q_known_q <= q_known_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign s         = s_q;
  assign r         = r_q;
  assign pat_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign q_model   = q_model_q;

`ifdef SR_DRIVER_CHECK_EN
  logic exp_q;
  logic vld_q;
  logic mismatch_q, mismatch_d;

  // Flip-flop updates one edge after s/r appear; compare one edge later still.
  always_comb begin
    mismatch_d = (mismatch_q & ~mismatch_clr) | (vld_q & (q_fb != exp_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q      <= 1'b0;
      vld_q      <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      exp_q      <= q_model_q;
      vld_q      <= busy_q;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`else
  logic unused_fb;
  assign unused_fb = q_fb ^ mismatch_clr;
  assign mismatch  = 1'b0;
`endif

endmodule

// File: tb/tb_sr_pattern_driver.sv
// Scoreboard bench for sr_pattern_driver with a behavioural SR flip-flop on q_fb.
module tb_sr_pattern_driver;

  localparam int unsigned W = 8;
`ifdef SR_DRIVER_CHECK_EN
  localparam logic MM_FORCED = 1'b1;
`else
  localparam logic MM_FORCED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] pat_in = '0;
  logic         pat_valid = 1'b0;
  logic         pat_ready, s, r, busy, done, q_model, q_fb, mismatch;
  logic         mismatch_clr = 1'b0;
  logic         ffq = 1'b0;
  logic         force_fb = 1'b0;

  int n_checks = 0;
  int n_err = 0;

  typedef struct packed {
    logic s, r, busy, done, ready, qm;
  } exp_t;

  exp_t sb[$];
  logic mq = 1'b0;
  logic mk = 1'b0;
  int   cnt = 0;

  sr_pattern_driver #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .pat_in(pat_in), .pat_valid(pat_valid), .pat_ready(pat_ready),
    .s(s), .r(r), .busy(busy), .done(done), .q_model(q_model),
    .q_fb(q_fb), .mismatch(mismatch), .mismatch_clr(mismatch_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s && !r) ffq <= 1'b1;
    else if (r && !s) ffq <= 1'b0;
  end
  assign q_fb = force_fb ? 1'b0 : ffq;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk_e(logic es, logic er, logic eb, logic ed, logic erd, logic eq);
    exp_t e;
    e.s = es; e.r = er; e.busy = eb; e.done = ed; e.ready = erd; e.qm = eq;
    return e;
  endfunction

  // Reference model: on acceptance, push the full expected output sequence.
  always @(posedge clk) begin
    logic [W-1:0] p;
    logic t, es, er;
    if (rst) begin
      sb.delete();
      mq  = 1'b0;
      mk  = 1'b0;
      cnt = 0;
    end else if (cnt != 0) begin
      cnt--;
    end else if (pat_valid) begin
      p = pat_in;
      sb.push_back(mk_e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mq));
      for (int i = 0; i < W; i++) begin
        t = p[i];
        if (!mk)          begin es = t;    er = !t;   end
        else if (t == mq) begin es = 1'b0; er = 1'b0; end
        else if (t)       begin es = 1'b1; er = 1'b0; end
        else              begin es = 1'b0; er = 1'b1; end
        mq = t;
        mk = 1'b1;
        sb.push_back(mk_e(es, er, 1'b1, 1'b0, 1'b0, mq));
      end
      sb.push_back(mk_e(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mq));
      cnt = 10;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) e = sb.pop_front();
    else e = mk_e(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mq);
    check_eq("cycle{s,r,busy,done,ready,q}", {s, r, busy, done, pat_ready, q_model}, e);
    check_eq("sr_legal", s & r, 0);
  end

  int last_wait = 0;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic offer(input logic [W-1:0] p, input bit hold);
    int n = 0;
    @(negedge clk);
    pat_in    = p;
    pat_valid = 1'b1;
    while (!pat_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check_eq("offer_timeout", pat_ready, 1);
    @(posedge clk);
    #1;
    if (!hold) pat_valid = 1'b0;
    last_wait = n;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || !pat_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check_eq("idle_timeout", pat_ready, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("reset_state", {s, r, busy, done, pat_ready, q_model, mismatch}, 7'b0000100);

    // A5 then FF back to back: FF is all holds from q=1.
    offer(8'hA5, 1'b1);
    offer(8'hFF, 1'b0);
    check_eq("ff_follow_wait", last_wait, 10);
    wait_idle();
    check_eq("q_after_ff", q_model, 1);

    // From reset, all-zero pattern forces an explicit first reset.
    do_reset();
    offer(8'h00, 1'b0);
    wait_idle();
    check_eq("q_after_00", q_model, 0);

    // Reset during bit 3 discards the pattern and the known-q state.
    offer(8'hA5, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_mid{busy,done,ready,q}", {busy, done, pat_ready, q_model}, 4'b0010);
    offer(8'hFF, 1'b0);
    wait_idle();

    // Offer held through the drive: second pattern waits for the post-done idle cycle.
    offer(8'hA5, 1'b1);
    offer(8'h3C, 1'b0);
    check_eq("hold_wait", last_wait, 10);
    wait_idle();
    check_eq("mm_clean", mismatch, 0);

    // Feedback checker.
    do_reset();
    offer(8'hA5, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);
    check_eq("mm_a5", mismatch, 0);
    force_fb = 1'b1;
    offer(8'hFF, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("mm_E2", mismatch, 0);
    @(posedge clk);
    #1;
    check_eq("mm_E3", mismatch, MM_FORCED);
    wait_idle();
    repeat (2) @(negedge clk);
    check_eq("mm_sticky", mismatch, MM_FORCED);
    force_fb = 1'b0;
    mismatch_clr = 1'b1;
    @(negedge clk);
    mismatch_clr = 1'b0;
    @(negedge clk);
    check_eq("mm_cleared", mismatch, 0);

    check_eq("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
